spi_master: RTL

- SPI bus master (mode 0: CPOL=0, CPHA=0, MSB first) that drives SPI peripherals such as the bit-reverse test slave.
- Sits behind the SoC APB/MMIO register glue.
- Takes one transfer command (TX data, bit length, slave select, divider) over a valid/ready handshake.
- Runs the SPI bit sequence, then returns the captured MISO bits over a valid/ready response handshake.

---
 rtl/spi_master_pkg.sv | 16 +
 rtl/spi_clkdiv.sv | 39 +++
 rtl/spi_master.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/spi_master_pkg.sv
// Shared state encodings and SPI mode-0 idle levels for the spi_master slice.
package spi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

  localparam logic SCK_IDLE  = 1'b0;
  localparam logic MOSI_IDLE = 1'b1;

endpackage

// File: rtl/spi_clkdiv.sv
// Half-period down-counter for spi_master; tick marks the last cycle of a phase.
// Latency: tick is combinational from the counter, one cycle after a load of 0.
// Backpressure: none; counts only while en is high, load always wins.
module spi_clkdiv
  import spi_master_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] load_val,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first; SPI_MASTER_TRACE_EN adds sim-only trace and illegal-state fatal.
// Latency: handshake cycle to resp_valid = 1 + (div+1)*(2*len+1) cycles.
// Backpressure: req_ready only in IDLE; resp_valid/resp_data held until resp_ready.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 7,
  parameter int SS_WIDTH   = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic [SS_WIDTH-1:0]   req_ss,
  input  logic [DIV_WIDTH-1:0]  req_div,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  busy,
  output logic                  sck,
  output logic [SS_WIDTH-1:0]   ss,
  output logic                  mosi,
  input  logic                  miso
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [LEN_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic                  sck_q, sck_d;
  logic [SS_WIDTH-1:0]   ss_q, ss_d;
  logic                  mosi_q, mosi_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  busy_q, busy_d;
  logic                  req_ready_q, req_ready_d;

  logic                  cd_load;
  logic [DIV_WIDTH-1:0]  cd_val;
  logic                  cd_tick;

  logic [LEN_WIDTH-1:0]  len_eff;
  logic [DATA_WIDTH-1:0] tx_align;

  // Left-align the TX word so the current bit always sits in the MSB.
  assign len_eff  = (req_len == '0) ? LEN_WIDTH'(DATA_WIDTH) : req_len;
  assign tx_align = req_data << (LEN_WIDTH'(DATA_WIDTH) - len_eff);

  spi_clkdiv #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_clkdiv (
    .clock    (clock),
    .reset    (reset),
    .load     (cd_load),
    .en       (busy_q),
    .load_val (cd_val),
    .tick     (cd_tick)
  );

  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    bit_cnt_d    = bit_cnt_q;
    div_d        = div_q;
    sck_d        = sck_q;
    ss_d         = ss_q;
    mosi_d       = mosi_q;
    resp_valid_d = resp_valid_q;
    cd_load      = 1'b0;
    cd_val       = div_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d   = ST_SETUP;
          tx_d      = tx_align;
          rx_d      = '0;
          bit_cnt_d = len_eff;
          div_d     = req_div;
          ss_d      = ~req_ss;
          sck_d     = SCK_IDLE;
          mosi_d    = tx_align[DATA_WIDTH-1];
          cd_load   = 1'b1;
          cd_val    = req_div;
        end
      end
      ST_SETUP, ST_LOW: begin
        // Rising sck: capture MISO as sck goes high.
        if (cd_tick) begin
          state_d   = ST_HIGH;
          sck_d     = 1'b1;
          rx_d      = {rx_q[DATA_WIDTH-2:0], miso};
          bit_cnt_d = bit_cnt_q - LEN_WIDTH'(1);
          cd_load   = 1'b1;
        end
      end
      ST_HIGH: begin
        if (cd_tick) begin
          sck_d   = SCK_IDLE;
          cd_load = 1'b1;
          if (bit_cnt_q == '0) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_LOW;
            tx_d    = tx_q << 1;
            mosi_d  = tx_q[DATA_WIDTH-2];
          end
        end
      end
      ST_HOLD: begin
        if (cd_tick) begin
          state_d      = ST_RESP;
          ss_d         = '1;
          mosi_d       = MOSI_IDLE;
          resp_valid_d = 1'b1;
          cd_load      = 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        sck_d        = SCK_IDLE;
        ss_d         = '1;
        mosi_d       = MOSI_IDLE;
        resp_valid_d = 1'b0;
`ifdef SPI_MASTER_TRACE_EN
        $fatal(1, "spi_master: illegal state %0d", state_q);
`endif
      end
    endcase

    busy_d      = (state_d != ST_IDLE);
    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      tx_q         <= '0;
      rx_q         <= '0;
      bit_cnt_q    <= '0;
      div_q        <= '0;
      sck_q        <= SCK_IDLE;
      ss_q         <= '1;
      mosi_q       <= MOSI_IDLE;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      bit_cnt_q    <= bit_cnt_d;
      div_q        <= div_d;
      sck_q        <= sck_d;
      ss_q         <= ss_d;
      mosi_q       <= mosi_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
      req_ready_q  <= req_ready_d;
    end
  end

`ifdef SPI_MASTER_TRACE_EN
  always_ff @(posedge clock) begin
    if (!reset && (state_q == ST_IDLE) && req_valid) begin
      $write("spi_master: accept ss=%h len=%0d data=%h\n", req_ss, len_eff, req_data);
    end
    if (!reset && resp_valid_q && resp_ready) begin
      $write("spi_master: resp data=%h\n", rx_q);
    end
  end
`endif

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = rx_q;
  assign busy       = busy_q;
  assign sck        = sck_q;
  assign ss         = ss_q;
  assign mosi       = mosi_q;

endmodule
